// File: rtl/mdpad_pkg.sv
// Shared button indices, pad phase encoding and the pad output mapping.
package mdpad_pkg;

  localparam int unsigned BTN_U = 0;
  localparam int unsigned BTN_D = 1;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_R = 3;
  localparam int unsigned BTN_B = 4;
  localparam int unsigned BTN_C = 5;
  localparam int unsigned BTN_A = 6;
  localparam int unsigned BTN_S = 7;
  localparam int unsigned BTN_Z = 8;
  localparam int unsigned BTN_Y = 9;
  localparam int unsigned BTN_X = 10;
  localparam int unsigned BTN_M = 11;

  typedef enum logic [2:0] {PH_IDLE, PH_1, PH_2, PH_SIX, PH_POST} phase_e;

  localparam phase_e PH_MAX = PH_POST;

  // Returns {up, down, left, right, p6, p9}, active low.
  function automatic logic [5:0] pad_map(input logic       i_sel,
                                         input phase_e     i_ph,
                                         input logic [11:0] i_btn,
                                         input logic       i_six);
    logic [5:0] v;
    logic       six_ph;
    six_ph = i_six && (i_ph == PH_SIX);
    if (i_sel) begin
      if (six_ph) begin
        v = {~i_btn[BTN_Z], ~i_btn[BTN_Y], ~i_btn[BTN_X], ~i_btn[BTN_M],
             ~i_btn[BTN_B], ~i_btn[BTN_C]};
      end else begin
        v = {~i_btn[BTN_U], ~i_btn[BTN_D], ~i_btn[BTN_L], ~i_btn[BTN_R],
             ~i_btn[BTN_B], ~i_btn[BTN_C]};
      end
    end else if (six_ph) begin
      v = {4'b0000, ~i_btn[BTN_A], ~i_btn[BTN_S]};
    end else if (i_six && (i_ph == PH_POST)) begin
      v = {4'b1111, ~i_btn[BTN_A], ~i_btn[BTN_S]};
    end else begin
      v = {~i_btn[BTN_U], ~i_btn[BTN_D], 2'b00, ~i_btn[BTN_A], ~i_btn[BTN_S]};
    end
    return v;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Select-line synchroniser followed by a registered level and falling-edge pulse.
module sync_edge
  import mdpad_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_res_n,
  input  logic i_async,
  output logic o_sel,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_sel;
  logic              r_fall;

  // Level and pulse are registered together so they stay aligned.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_sync <= '1;
      r_sel  <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_sel  <= r_sync[STAGES-1];
      r_fall <= r_sel & ~r_sync[STAGES-1];
    end
  end

  assign o_sel  = r_sel;
  assign o_fall = r_fall;

endmodule

// File: rtl/megadrive_pad_responder.sv
// Mega Drive pad responder; define PAD_SIX_BUTTON_EN for the six-button pad,
// otherwise a plain three-button pad is built.
module megadrive_pad_responder
  import mdpad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 36000
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        select_i,
  input  logic [11:0] buttons_i,
  output logic        pad_up_o,
  output logic        pad_down_o,
  output logic        pad_left_o,
  output logic        pad_right_o,
  output logic        pad_p6_o,
  output logic        pad_p9_o,
  output logic [2:0]  phase_o
);

  logic   w_sel;
  logic   w_fall;
  logic   w_expire;
  phase_e r_phase;
  phase_e w_phase_d;
  logic [5:0] r_pad;

  sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .i_clk  (clk_i),
    .i_res_n(res_n_i),
    .i_async(select_i),
    .o_sel  (w_sel),
    .o_fall (w_fall)
  );

`ifdef PAD_SIX_BUTTON_EN
  localparam logic SIX = 1'b1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] r_to;

  assign w_expire = (r_to == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_to <= '0;
    end else if (w_fall) begin
      r_to <= '0;
    end else if (!w_expire) begin
      r_to <= r_to + TW'(1);
    end
  end
`else
  localparam logic SIX = 1'b0;
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_expire         = 1'b0;
`endif

  // A falling edge always beats a coincident timeout.
  always_comb begin
    w_phase_d = r_phase;
    if (w_fall) begin
      if (r_phase != PH_MAX) begin
        w_phase_d = phase_e'(r_phase + 3'd1);
      end
    end else if (w_expire) begin
      w_phase_d = PH_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_phase <= PH_IDLE;
      r_pad   <= '1;
    end else begin
      r_phase <= w_phase_d;
      r_pad   <= pad_map(w_sel, w_phase_d, buttons_i, SIX);
    end
  end

  assign {pad_up_o, pad_down_o, pad_left_o, pad_right_o, pad_p6_o, pad_p9_o} = r_pad;
  assign phase_o = r_phase;

endmodule

// File: tb/tb_megadrive_pad_responder.sv
// Self-checking bench for megadrive_pad_responder, valid with or without PAD_SIX_BUTTON_EN.
module tb_megadrive_pad_responder;

  localparam int unsigned S = 2;
  localparam int unsigned T = 200;

`ifdef PAD_SIX_BUTTON_EN
  localparam bit         SIX        = 1'b1;
  localparam logic [5:0] EXP_L3_900 = 6'b000011;
  localparam logic [5:0] EXP_H3_900 = 6'b011011;
  localparam logic [5:0] EXP_L4_900 = 6'b111111;
  localparam logic [5:0] EXP_L3_000 = 6'b000011;
  localparam logic [2:0] EXP_PH_TO  = 3'd0;
  localparam logic [2:0] EXP_PH_NXT = 3'd1;
`else
  localparam bit         SIX        = 1'b0;
  localparam logic [5:0] EXP_L3_900 = 6'b110011;
  localparam logic [5:0] EXP_H3_900 = 6'b111111;
  localparam logic [5:0] EXP_L4_900 = 6'b110011;
  localparam logic [5:0] EXP_L3_000 = 6'b110011;
  localparam logic [2:0] EXP_PH_TO  = 3'd3;
  localparam logic [2:0] EXP_PH_NXT = 3'd4;
`endif

  logic        clk     = 1'b0;
  logic        res_n   = 1'b0;
  logic        select  = 1'b1;
  logic [11:0] buttons = 12'h000;
  logic        up, down, left, right, p6, p9;
  logic [2:0]  phase;
  logic [5:0]  pads;

  int checks = 0;
  int errors = 0;

  megadrive_pad_responder #(
    .SYNC_STAGES   (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i      (clk),
    .res_n_i    (res_n),
    .select_i   (select),
    .buttons_i  (buttons),
    .pad_up_o   (up),
    .pad_down_o (down),
    .pad_left_o (left),
    .pad_right_o(right),
    .pad_p6_o   (p6),
    .pad_p9_o   (p9),
    .phase_o    (phase)
  );

  assign pads = {up, down, left, right, p6, p9};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pads=%b phase=%0d, expected pads=%b phase=%0d at %0t",
               name, act[8:3], act[2:0], exp[8:3], exp[2:0], $time);
    end
  endtask

  // Expected {up,down,left,right,p6,p9} for a given select level, phase and buttons.
  function automatic logic [5:0] model_map(input logic sel, input int ph, input logic [11:0] b);
    if (sel) begin
      if (SIX && ph == 3) return {~b[8], ~b[9], ~b[10], ~b[11], ~b[4], ~b[5]};
      return {~b[0], ~b[1], ~b[2], ~b[3], ~b[4], ~b[5]};
    end
    if (SIX && ph == 3) return {4'b0000, ~b[6], ~b[7]};
    if (SIX && ph == 4) return {4'b1111, ~b[6], ~b[7]};
    return {~b[0], ~b[1], 2'b00, ~b[6], ~b[7]};
  endfunction

  // Model: select history as seen at each clock, falls counted, cycles since last fall.
  logic       hist [0:S+2];
  int         m_phase;
  int         since;
  logic [5:0] m_pad;

  always @(posedge clk) begin
    if (!res_n) begin
      for (int k = 0; k <= S + 2; k++) hist[k] = 1'b1;
      m_phase = 0;
      since   = 0;
      m_pad   = 6'h3F;
    end else begin
      for (int k = S + 2; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = select;
      if (!hist[S+1] && hist[S+2]) begin
        if (m_phase < 4) m_phase++;
        since = 0;
      end else begin
        since++;
        if (SIX && since >= T) m_phase = 0;
      end
      m_pad = model_map(hist[S+1], m_phase, buttons);
    end
    #1;
    check("cycle", {pads, phase}, {m_pad, 3'(m_phase)});
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_sel(input logic v);
    @(negedge clk);
    select = v;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    res_n  = 1'b0;
    select = 1'b1;
    hold(3);
    res_n = 1'b1;
  endtask

  task automatic two_falls(input int len);
    for (int i = 0; i < 2; i++) begin
      drive_sel(1'b0);
      hold(len);
      drive_sel(1'b1);
      hold(len);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("reset", {pads, phase}, {6'h3F, 3'd0});
    @(negedge clk);
    res_n = 1'b1;
    wait_n(5);
    check("idle", {pads, phase}, {6'h3F, 3'd0});

    // Three-button select toggle with U, A, S pressed.
    @(negedge clk);
    buttons = 12'h0C1;
    wait_n(2);
    check("t2_high", {pads, phase}, {6'b011111, 3'd0});
    drive_sel(1'b0);
    wait_n(S + 1);
    check("t2_latency", {pads, phase}, {6'b011111, 3'd0});
    wait_n(1);
    check("t2_low", {pads, phase}, {6'b010000, 3'd1});
    hold(20);
    drive_sel(1'b1);
    wait_n(S + 2);
    check("t2_back", {pads, phase}, {6'b011111, 3'd1});

    // Six-button sequence with M and Z pressed.
    buttons = 12'h900;
    do_reset();
    wait_n(5);
    two_falls(70);
    drive_sel(1'b0);
    wait_n(S + 2);
    check("t3_low3", {pads, phase}, {EXP_L3_900, 3'd3});
    hold(70);
    drive_sel(1'b1);
    wait_n(S + 2);
    check("t3_high3", {pads, phase}, {EXP_H3_900, 3'd3});
    hold(70);
    drive_sel(1'b0);
    wait_n(S + 2);
    check("t3_low4", {pads, phase}, {EXP_L4_900, 3'd4});
    hold(70);
    drive_sel(1'b1);
    hold(70);
    drive_sel(1'b0);
    wait_n(S + 2);
    check("t3_saturate", {pads, phase}, {EXP_L4_900, 3'd4});

    // Timeout after three falls.
    do_reset();
    wait_n(5);
    two_falls(70);
    drive_sel(1'b0);
    hold(70);
    drive_sel(1'b1);
    hold(250);
    wait_n(1);
    check("t4_timeout", {pads, phase}, {6'h3F, EXP_PH_TO});
    drive_sel(1'b0);
    wait_n(S + 2);
    check("t4_next_low", {pads, phase}, {6'b110011, EXP_PH_NXT});
    hold(20);
    drive_sel(1'b1);

    // Asynchronous reset in phase 3.
    buttons = 12'h000;
    do_reset();
    wait_n(5);
    two_falls(40);
    drive_sel(1'b0);
    wait_n(S + 2);
    check("t5_low3", {pads, phase}, {EXP_L3_000, 3'd3});
    hold(10);
    @(negedge clk);
    #1 res_n = 1'b0;
    #1 check("t5_async", {pads, phase}, {6'h3F, 3'd0});
    select = 1'b1;
    hold(3);
    res_n = 1'b1;
    wait_n(5);
    check("t5_released", {pads, phase}, {6'h3F, 3'd0});
    drive_sel(1'b0);
    wait_n(S + 2);
    check("t5_restart", {pads, phase}, {6'b110011, 3'd1});
    hold(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
